// File: rtl/router_ovch_credit_tx_if.sv
// Link-side bundle of the output-VC transmitter: per-VC upstream handshake,
// registered link outputs and the downstream credit return path.
interface router_ovch_credit_tx_if #(
    parameter int NUM_VC = 2,
    parameter int FLIT_W = 16,
    parameter int VW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
);
    logic [NUM_VC-1:0]        in_valid;
    logic [NUM_VC*FLIT_W-1:0] in_flit;
    logic [NUM_VC-1:0]        in_tail;
    logic [NUM_VC-1:0]        in_ready;
    logic                     out_valid;
    logic [VW-1:0]            out_vc;
    logic [FLIT_W-1:0]        out_flit;
    logic                     out_tail;
    logic                     credit_valid;
    logic [VW-1:0]            credit_vc;
    logic                     credit_err;

    modport master (
        output in_valid, in_flit, in_tail, credit_valid, credit_vc,
        input  in_ready, out_valid, out_vc, out_flit, out_tail, credit_err
    );

    modport slave (
        input  in_valid, in_flit, in_tail, credit_valid, credit_vc,
        output in_ready, out_valid, out_vc, out_flit, out_tail, credit_err
    );
endinterface

// File: rtl/router_ovch_credit_tx.sv
// Output-VC transmitter: round-robin picks one credit-holding VC per cycle and
// registers its flit onto the link; returned credits refill per-VC counters.
module router_ovch_credit_tx #(
    parameter int NUM_VC  = 2,
    parameter int FLIT_W  = 16,
    parameter int CREDITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    router_ovch_credit_tx_if.slave bus
);
    localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [VW:0]   NUM_VC_W = (VW + 1)'(NUM_VC);

    logic [CW-1:0]     cnt_q [NUM_VC];
    logic [CW-1:0]     cnt_d [NUM_VC];
    logic [VW-1:0]     rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [VW-1:0]     out_vc_q, out_vc_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic              out_tail_q, out_tail_d;
    logic              credit_err_q, credit_err_d;

    logic [NUM_VC-1:0] elig_s;
    logic [NUM_VC-1:0] send_s;
    logic [NUM_VC-1:0] ret_s;
    logic              gnt_vld_s;
    logic [VW-1:0]     gnt_idx_s;
    logic              ovf_s;
    logic              bad_vc_s;

    // VC index base+off wrapped modulo NUM_VC without a divider
    function automatic logic [VW-1:0] wrap_add(input logic [VW-1:0] base, input int unsigned off);
        int unsigned s;
        s = off + 32'(base);
        if (s >= NUM_VC) begin
            s = s - NUM_VC;
        end else begin
            s = s;
        end
        return VW'(s);
    endfunction

    // eligibility and first-eligible search starting at the round-robin pointer
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            elig_s[v] = bus.in_valid[v] & (cnt_q[v] != '0);
        end
        for (int i = 0; i < NUM_VC; i++) begin
            if (!gnt_vld_s && elig_s[wrap_add(rr_q, i)]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = wrap_add(rr_q, i);
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // one-hot grant / credit-return decode; in_ready is held low during reset
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            send_s[v]       = gnt_vld_s & (gnt_idx_s == VW'(v));
            ret_s[v]        = bus.credit_valid & (bus.credit_vc == VW'(v));
            bus.in_ready[v] = send_s[v] & reset;
        end
    end

    // counter update, error detection, pointer advance and link register load
    always_comb begin
        ovf_s    = 1'b0;
        bad_vc_s = bus.credit_valid & ({1'b0, bus.credit_vc} >= NUM_VC_W);
        for (int v = 0; v < NUM_VC; v++) begin
            if (send_s[v] && !ret_s[v]) begin
                cnt_d[v] = cnt_q[v] - CW'(1);
            end else if (ret_s[v] && !send_s[v]) begin
                if (cnt_q[v] == CRED_MAX) begin
                    cnt_d[v] = cnt_q[v];
                    ovf_s    = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + CW'(1);
                end
            end else begin
                cnt_d[v] = cnt_q[v];
            end
        end
        credit_err_d = credit_err_q | ovf_s | bad_vc_s;
        if (gnt_vld_s) begin
            rr_d        = wrap_add(gnt_idx_s, 1);
            out_valid_d = 1'b1;
            out_vc_d    = gnt_idx_s;
            out_flit_d  = bus.in_flit[gnt_idx_s*FLIT_W +: FLIT_W];
            out_tail_d  = bus.in_tail[gnt_idx_s];
        end else begin
            rr_d        = rr_q;
            out_valid_d = 1'b0;
            out_vc_d    = out_vc_q;
            out_flit_d  = out_flit_q;
            out_tail_d  = out_tail_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                cnt_q[v] <= CRED_MAX;
            end
            rr_q         <= '0;
            out_valid_q  <= 1'b0;
            out_vc_q     <= '0;
            out_flit_q   <= '0;
            out_tail_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                cnt_q[v] <= cnt_d[v];
            end
            rr_q         <= rr_d;
            out_valid_q  <= out_valid_d;
            out_vc_q     <= out_vc_d;
            out_flit_q   <= out_flit_d;
            out_tail_q   <= out_tail_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_vc     = out_vc_q;
    assign bus.out_flit   = out_flit_q;
    assign bus.out_tail   = out_tail_q;
    assign bus.credit_err = credit_err_q;
endmodule

// File: tb/tb_router_ovch_credit_tx.sv
// Self-checking bench for router_ovch_credit_tx: vector table, directed corner
// sequences and a random phase scored against a credit/round-robin model.
module tb_router_ovch_credit_tx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    router_ovch_credit_tx_if #(.NUM_VC(2), .FLIT_W(16)) bus ();
    router_ovch_credit_tx_if #(.NUM_VC(3), .FLIT_W(16)) bus3 ();

    router_ovch_credit_tx #(.NUM_VC(2), .FLIT_W(16), .CREDITS(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    router_ovch_credit_tx #(.NUM_VC(3), .FLIT_W(16), .CREDITS(4)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  t;
        logic [15:0] f0;
        logic [15:0] f1;
        logic        cv;
        logic        cvc;
        logic [1:0]  e_rdy;
        logic        e_ov;
        logic        e_vc;
        logic [15:0] e_fl;
        logic        e_tl;
        logic        e_err;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic [1:0] v, logic [1:0] t, logic [15:0] f0, logic [15:0] f1,
                                logic cv, logic cvc, logic [1:0] rdy, logic ov, logic vc,
                                logic [15:0] fl, logic tl, logic err);
        vec_t r;
        r.v = v; r.t = t; r.f0 = f0; r.f1 = f1; r.cv = cv; r.cvc = cvc;
        r.e_rdy = rdy; r.e_ov = ov; r.e_vc = vc; r.e_fl = fl; r.e_tl = tl; r.e_err = err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] t, input logic [15:0] f0,
                         input logic [15:0] f1, input logic cv, input logic cvc);
        bus.in_valid     = v;
        bus.in_tail      = t;
        bus.in_flit      = {f1, f0};
        bus.credit_valid = cv;
        bus.credit_vc    = cvc;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b1;
    endtask

    // cycle-limit guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m_cnt[2];
        int m_rr;
        int g;
        logic m_ov, m_vc, m_tl, m_err;
        logic [15:0] m_fl;
        logic [1:0] rv, rt, erdy;
        logic [15:0] rf0, rf1;
        logic rcv, rcvc;

        // build vector table: VC1 credit exhaustion, credit return, VC0 head/tail
        tbl[0]  = mk(2'b10, 2'b00, 16'h0000, 16'hA001, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        tbl[1]  = mk(2'b10, 2'b00, 16'h0000, 16'hA002, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 16'hA001, 1'b0, 1'b0);
        tbl[2]  = mk(2'b10, 2'b00, 16'h0000, 16'hA003, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 16'hA002, 1'b0, 1'b0);
        tbl[3]  = mk(2'b10, 2'b00, 16'h0000, 16'hA004, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 16'hA003, 1'b0, 1'b0);
        tbl[4]  = mk(2'b10, 2'b00, 16'h0000, 16'hA005, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 16'hA004, 1'b0, 1'b0);
        tbl[5]  = mk(2'b10, 2'b00, 16'h0000, 16'hA005, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 16'hA004, 1'b0, 1'b0);
        tbl[6]  = mk(2'b10, 2'b00, 16'h0000, 16'hA005, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 16'hA004, 1'b0, 1'b0);
        tbl[7]  = mk(2'b10, 2'b00, 16'h0000, 16'hA005, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 16'hA004, 1'b0, 1'b0);
        tbl[8]  = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 16'hA005, 1'b0, 1'b0);
        tbl[9]  = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 16'hA005, 1'b0, 1'b0);
        tbl[10] = mk(2'b01, 2'b00, 16'hB001, 16'h0000, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 16'hA005, 1'b0, 1'b0);
        tbl[11] = mk(2'b01, 2'b01, 16'hB002, 16'h0000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 16'hB001, 1'b0, 1'b0);
        tbl[12] = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 16'hB002, 1'b1, 1'b0);
        tbl[13] = mk(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'hB002, 1'b1, 1'b0);

        bus3.in_valid = 3'b000; bus3.in_flit = 48'h0; bus3.in_tail = 3'b000;
        bus3.credit_valid = 1'b0; bus3.credit_vc = 2'd0;
        drive(2'b11, 2'b11, 16'h1111, 16'h2222, 1'b0, 1'b0);

        // reset values with both VCs requesting
        next_cyc();
        #3;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_vc", bus.out_vc, 1'b0);
        chk("rst_out_flit", bus.out_flit, 16'h0000);
        chk("rst_out_tail", bus.out_tail, 1'b0);
        chk("rst_in_ready", bus.in_ready, 2'b00);
        chk("rst_credit_err", bus.credit_err, 1'b0);
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        next_cyc();
        reset = 1'b1;

        // out-of-range credit_vc on a three-VC instance
        bus3.credit_valid = 1'b1;
        bus3.credit_vc = 2'd3;
        #3;
        chk("vc3_err_before", bus3.credit_err, 1'b0);
        next_cyc();
        bus3.credit_valid = 1'b0;
        #3;
        chk("vc3_err_after", bus3.credit_err, 1'b1);
        next_cyc();

        // vector table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].t, tbl[i].f0, tbl[i].f1, tbl[i].cv, tbl[i].cvc);
            #3;
            chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_vc", i), bus.out_vc, tbl[i].e_vc);
            chk($sformatf("tbl%0d_out_flit", i), bus.out_flit, tbl[i].e_fl);
            chk($sformatf("tbl%0d_out_tail", i), bus.out_tail, tbl[i].e_tl);
            chk($sformatf("tbl%0d_credit_err", i), bus.credit_err, tbl[i].e_err);
            next_cyc();
        end

        // VC0 at two credits: send plus same-cycle return keeps it at two
        drive(2'b01, 2'b00, 16'hC001, 16'h0000, 1'b1, 1'b0);
        #3; chk("sim_s0_ready", bus.in_ready, 2'b01);
        next_cyc();
        drive(2'b01, 2'b00, 16'hC002, 16'h0000, 1'b0, 1'b0);
        #3; chk("sim_s1_ready", bus.in_ready, 2'b01);
        chk("sim_s1_flit", bus.out_flit, 16'hC001);
        next_cyc();
        drive(2'b01, 2'b00, 16'hC003, 16'h0000, 1'b0, 1'b0);
        #3; chk("sim_s2_ready", bus.in_ready, 2'b01);
        next_cyc();
        drive(2'b01, 2'b00, 16'hC004, 16'h0000, 1'b0, 1'b0);
        #3; chk("sim_s3_ready", bus.in_ready, 2'b00);
        chk("sim_err", bus.credit_err, 1'b0);
        next_cyc();

        // refill both VCs to full
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, i[0]);
            next_cyc();
        end
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #3; chk("refill_err", bus.credit_err, 1'b0);
        next_cyc();

        // overflow on full VC0: sticky error, counter stays saturated
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        #3; chk("ovf_err_before", bus.credit_err, 1'b0);
        next_cyc();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #3; chk("ovf_err_next", bus.credit_err, 1'b1);
        next_cyc();
        for (int k = 0; k < 6; k++) begin
            drive(2'b01, 2'b00, 16'hD000 + 16'(k), 16'h0000, 1'b0, 1'b0);
            #3; chk($sformatf("ovf_sat_ready%0d", k), bus.in_ready, (k < 4) ? 2'b01 : 2'b00);
            next_cyc();
        end
        #3; chk("ovf_err_sticky", bus.credit_err, 1'b1);

        // reset asserted mid-stream
        drive(2'b11, 2'b11, 16'hE001, 16'hE101, 1'b0, 1'b0);
        next_cyc();
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_out_vc", bus.out_vc, 1'b0);
        chk("mid_rst_out_flit", bus.out_flit, 16'h0000);
        chk("mid_rst_out_tail", bus.out_tail, 1'b0);
        chk("mid_rst_in_ready", bus.in_ready, 2'b00);
        chk("mid_rst_err", bus.credit_err, 1'b0);
        next_cyc();
        reset = 1'b1;
        drive(2'b01, 2'b00, 16'hF001, 16'h0000, 1'b0, 1'b0);
        #3; chk("post_rst_ready", bus.in_ready, 2'b01);
        next_cyc();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #3;
        chk("post_rst_ov", bus.out_valid, 1'b1);
        chk("post_rst_flit", bus.out_flit, 16'hF001);

        // round-robin fairness from reset with a credit back every cycle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(2'b11, 2'b00, 16'h1000 + 16'(k), 16'h2000 + 16'(k), k > 0, (k > 0) ? (k - 1) % 2 : 0);
            #3;
            chk($sformatf("rr%0d_ready", k), bus.in_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                chk($sformatf("rr%0d_ov", k), bus.out_valid, 1'b1);
                chk($sformatf("rr%0d_vc", k), bus.out_vc, (k - 1) % 2);
            end
            next_cyc();
        end
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1);
        next_cyc();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #3; chk("rr_err", bus.credit_err, 1'b0);

        // random traffic against the reference model
        do_reset();
        m_cnt[0] = 4; m_cnt[1] = 4; m_rr = 0;
        m_ov = 1'b0; m_vc = 1'b0; m_fl = 16'h0; m_tl = 1'b0; m_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rv = 2'($urandom_range(0, 3));
            rt = 2'($urandom_range(0, 3));
            rf0 = 16'($urandom);
            rf1 = 16'($urandom);
            rcv = ($urandom_range(0, 9) < 4);
            rcvc = 1'($urandom_range(0, 1));
            drive(rv, rt, rf0, rf1, rcv, rcvc);
            g = -1;
            for (int j = 0; j < 2; j++) begin
                if (g < 0 && rv[(m_rr + j) % 2] && m_cnt[(m_rr + j) % 2] > 0) g = (m_rr + j) % 2;
            end
            erdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            #3;
            chk("rnd_in_ready", bus.in_ready, erdy);
            chk("rnd_out_valid", bus.out_valid, m_ov);
            chk("rnd_out_vc", bus.out_vc, m_vc);
            chk("rnd_out_flit", bus.out_flit, m_fl);
            chk("rnd_out_tail", bus.out_tail, m_tl);
            chk("rnd_credit_err", bus.credit_err, m_err);
            next_cyc();
            if (g >= 0) begin
                m_ov = 1'b1;
                m_vc = (g == 1);
                m_fl = (g == 0) ? rf0 : rf1;
                m_tl = rt[g];
                m_rr = (g + 1) % 2;
                if (rcv && int'(rcvc) == g) begin
                    rcv = 1'b0;
                end else begin
                    m_cnt[g] = m_cnt[g] - 1;
                end
            end else begin
                m_ov = 1'b0;
            end
            if (rcv) begin
                if (m_cnt[rcvc] == 4) m_err = 1'b1;
                else m_cnt[rcvc] = m_cnt[rcvc] + 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/router_ovch_credit_tx.md
# router_ovch_credit_tx

Output-virtual-channel transmitter for the router-wrap slice. It takes flits from NUM_VC per-VC upstream queues and spends per-VC credits that mirror the free slots of the downstream input-VC (IVCH) flip-flop buffers. Each cycle a round-robin arbiter picks one eligible VC and the flit goes onto a single registered link. Credits returned by the downstream IVCH side replenish the counters.

## Interface
- NUM_VC, 2: number of virtual channels, ≥2.
- FLIT_W, 16: flit payload width.
- CREDITS, 4: downstream IVCH depth per VC, which is also the initial credit count; ≥1.
- VW = max(1, clog2(NUM_VC)) and CW = clog2(CREDITS+1) are derived localparams.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous assert, active-low; deassertion is synchronous to clk from the top level.
- in_valid  in  NUM_VC  per-VC flit available.
- in_flit  in  NUM_VC*FLIT_W  per-VC flit; VC v occupies bits [v*FLIT_W +: FLIT_W].
- in_tail  in  NUM_VC  per-VC tail marker accompanying in_flit.
- in_ready  out  NUM_VC  one-hot-or-zero grant; the flit on VC v is consumed when in_valid[v] & in_ready[v].
- out_valid  out  1  link flit valid, registered.
- out_vc  out  VW  VC of the link flit, registered.
- out_flit  out  FLIT_W  link flit, registered.
- out_tail  out  1  link tail, registered.
- credit_valid  in  1  downstream returns one credit this cycle.
- credit_vc  in  VW  VC the returned credit belongs to.
- credit_err  out  1  sticky error: credit overflow or out-of-range credit_vc.

## Operation
- **Credit counters.** Each VC v has cnt[v] (CW bits), reset to CREDITS.
  - cnt[v] decrements on a transfer on VC v.
  - cnt[v] increments on credit_valid with credit_vc==v.
  - Both in the same cycle: cnt[v] is unchanged.
- **Eligibility.** elig[v] = in_valid[v] & (cnt[v] != 0).
- **Arbitration.**
  - Round-robin pointer rr (VW bits), reset 0.
  - Grant goes to the first eligible VC scanning rr, rr+1, …, wrapping modulo NUM_VC.
  - in_ready is combinational from elig and rr; no path from in_valid of one VC to in_ready of the same VC beyond elig.
  - On a grant to VC g, rr becomes (g+1) mod NUM_VC at the next edge. With no grant, rr holds.
  - Arbitration is per flit; flits of different VCs may interleave on the link.
- **Output register.**
  - On a grant, the next edge loads out_valid=1, out_vc=g, out_flit=in_flit[g], out_tail=in_tail[g].
  - With no grant, out_valid=0 and out_vc/out_flit/out_tail hold their last values.
  - The link has no backpressure; credits are the only flow control.
- **Credit errors.**
  - credit_valid with cnt[credit_vc]==CREDITS and no simultaneous send on that VC sets credit_err. The counter saturates at CREDITS.
  - credit_valid with credit_vc ≥ NUM_VC sets credit_err. The credit is dropped.
  - credit_err clears only on reset.
- **Reset mid-operation.** Asynchronously, out_valid→0, out_vc→0, out_flit→0, out_tail→0, rr→0, every cnt→CREDITS, credit_err→0. in_ready is forced to 0 while reset is low.

## Timing
- Transfer to link latency: 1 cycle. A flit accepted at edge N appears on out_* in cycle N+1.
- Link throughput: one flit per cycle across all VCs.
- Credit return to reuse: a credit presented in cycle N updates cnt at edge N. It can enable a grant in cycle N+1.
- A VC at cnt==0 is never granted; in_ready[v] stays 0 even if in_valid[v]=1.
- A single VC with in_valid held and CREDITS=4, with no returns, sends exactly 4 back-to-back flits and then stalls.

## Test plan
- **Reset values.** Assert reset mid-stream. Required: out_valid=0, out_vc=0, out_flit=0, in_ready=0, credit_err=0. After release, VC0 with in_valid=1 is granted in the first cycle.
- **Credit exhaustion.** VC1 only, in_valid held, flits 0xA001..0xA005, no credits returned. Required: out_valid high for 4 cycles with 0xA001..0xA004 and out_vc=1; 0xA005 stalls. After one credit_valid on VC1, 0xA005 appears 2 cycles after the credit.
- **Round-robin fairness.** Both VCs valid continuously, credits returned every cycle. Required: out_vc alternates 0,1,0,1 starting with 0 after reset.
- **Simultaneous send and return.** VC0 at cnt=2 sends a flit while a VC0 credit returns in the same cycle. Required: cnt stays 2 and there is no credit_err.
- **Credit overflow.** credit_valid on VC0 while cnt[0]=CREDITS and idle. Required: credit_err=1 from the next cycle onward and cnt[0] stays 4. With NUM_VC=3, credit_vc=3 also sets credit_err.
- **Tail propagation.** VC0 sends a head then a tail (in_tail 0 then 1). Required: out_tail is 0 then 1 in consecutive link cycles with out_vc=0.
